// File: rtl/vector_regfile_v4.sv
// Parametrised vector register file with per-byte writes, LMUL group read
// streaming (one valid/ready state machine per read port) and a busy
// scoreboard that holds reads of registers with outstanding writes.
module vector_regfile_v4 #(
  parameter int VLEN      = 64,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = 3,
  parameter int NUM_WR    = 2,
  parameter int ZERO_REG0 = 1,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int BYTES     = VLEN / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_RD-1:0]                rd_req_valid,
  output logic [NUM_RD-1:0]                rd_req_ready,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_req_addr,
  input  logic [NUM_RD-1:0][1:0]           rd_req_lmul,
  input  logic [NUM_RD-1:0][BYTES-1:0]     rd_byte_en,
  output logic [NUM_RD-1:0]                rd_data_valid,
  input  logic [NUM_RD-1:0]                rd_data_ready,
  output logic [NUM_RD-1:0][VLEN-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_data_last,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][BYTES-1:0]     wr_byte_en,
  input  logic [NUM_WR-1:0][VLEN-1:0]      wr_data,
  input  logic [NUM_WR-1:0]                wr_release,
  input  logic                             rsv_en,
  input  logic [ADDR_W-1:0]                rsv_addr,
  input  logic [1:0]                       rsv_lmul,
  output logic [NUM_REGS-1:0]              busy
);

  typedef enum logic {IDLE, RUN} rstate_t;

  logic [VLEN-1:0]   mem       [NUM_REGS];
  rstate_t           state_p0  [NUM_RD];
  rstate_t           state_nx  [NUM_RD];
  logic [ADDR_W-1:0] base_p0   [NUM_RD];
  logic [1:0]        lmul_p0   [NUM_RD];
  logic [BYTES-1:0]  ben_p0    [NUM_RD];
  logic [2:0]        beat_p0   [NUM_RD];
  logic [ADDR_W-1:0] cur_r     [NUM_RD];
  logic [VLEN-1:0]   beat_data [NUM_RD];
  logic [NUM_RD-1:0] load;
  logic [NUM_RD-1:0] last_beat;
  logic [NUM_REGS-1:0] rel_mask;
  logic [NUM_REGS-1:0] rsv_mask;
  logic [ADDR_W-1:0]   rsv_base;

  // Group base: clear the low lmul address bits so groups never wrap.
  function automatic logic [ADDR_W-1:0] align_base(input logic [ADDR_W-1:0] addr,
                                                   input logic [1:0] lmul);
    logic [ADDR_W-1:0] low;
    low = ADDR_W'((32'd1 << lmul) - 32'd1);
    return addr & ~low;
  endfunction

  function automatic logic [VLEN-1:0] byte_mask(input logic [BYTES-1:0] ben);
    logic [VLEN-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++) m[b*8 +: 8] = {8{ben[b]}};
    return m;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] r);
    return (ZERO_REG0 != 0) && (r == '0);
  endfunction

  // Scoreboard next-state inputs: releases from writes, group reservations.
  always_comb begin
    rel_mask = '0;
    rsv_mask = '0;
    rsv_base = align_base(rsv_addr, rsv_lmul);
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_release[w]) rel_mask[wr_addr[w]] = 1'b1;
    if (rsv_en)
      for (int k = 0; k < 8; k++)
        if (k < (32'sd1 <<< rsv_lmul)) rsv_mask[rsv_base + ADDR_W'(k)] = 1'b1;
    if (ZERO_REG0 != 0) rsv_mask[0] = 1'b0;
  end

  // Busy scoreboard; a same-cycle reservation overrides a release.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~rel_mask) | rsv_mask;
  end

  // Register storage; later write ports override earlier ones per byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        for (int b = 0; b < BYTES; b++)
          if (wr_en[w] && wr_byte_en[w][b] && !is_zero_reg(wr_addr[w]))
            mem[wr_addr[w]][b*8 +: 8] <= wr_data[w][b*8 +: 8];
    end
  end

  // Read FSM next state, beat-load decision and bypassed, masked beat data.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      state_nx[i]     = state_p0[i];
      load[i]         = 1'b0;
      rd_req_ready[i] = 1'b0;
      cur_r[i]        = base_p0[i] + ADDR_W'(beat_p0[i]);
      last_beat[i]    = (beat_p0[i] == ((3'd1 << lmul_p0[i]) - 3'd1));
      beat_data[i]    = is_zero_reg(cur_r[i]) ? '0 : mem[cur_r[i]];
      for (int w = 0; w < NUM_WR; w++)
        for (int b = 0; b < BYTES; b++)
          if (wr_en[w] && wr_byte_en[w][b] && wr_addr[w] == cur_r[i] && !is_zero_reg(cur_r[i]))
            beat_data[i][b*8 +: 8] = wr_data[w][b*8 +: 8];
      beat_data[i] = beat_data[i] & byte_mask(ben_p0[i]);
      case (state_p0[i])
        IDLE: begin
          rd_req_ready[i] = !reset;
          if (rd_req_valid[i]) state_nx[i] = RUN;
        end
        RUN: begin
          if ((!rd_data_valid[i] || rd_data_ready[i]) &&
              (is_zero_reg(cur_r[i]) || !busy[cur_r[i]] || rel_mask[cur_r[i]])) begin
            load[i] = 1'b1;
            if (last_beat[i]) state_nx[i] = IDLE;
          end
        end
        default: state_nx[i] = IDLE;
      endcase
    end
  end

  // Read FSM state, request latch and output slot per port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (reset) begin
        state_p0[i]      <= IDLE;
        base_p0[i]       <= '0;
        lmul_p0[i]       <= '0;
        ben_p0[i]        <= '0;
        beat_p0[i]       <= '0;
        rd_data_valid[i] <= 1'b0;
        rd_data[i]       <= '0;
        rd_data_last[i]  <= 1'b0;
      end else begin
        state_p0[i] <= state_nx[i];
        if (state_p0[i] == IDLE && rd_req_valid[i]) begin
          base_p0[i] <= align_base(rd_req_addr[i], rd_req_lmul[i]);
          lmul_p0[i] <= rd_req_lmul[i];
          ben_p0[i]  <= rd_byte_en[i];
          beat_p0[i] <= '0;
        end
        if (load[i]) begin
          rd_data[i]       <= beat_data[i];
          rd_data_last[i]  <= last_beat[i];
          rd_data_valid[i] <= 1'b1;
          beat_p0[i]       <= beat_p0[i] + 3'd1;
        end else if (rd_data_ready[i]) begin
          rd_data_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_regfile_v4.sv
// Directed bench for vector_regfile_v4: table of write/read vectors plus
// hand-written sequences for group streaming, scoreboard and reset cases.
module tb_vector_regfile_v4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       rd_req_valid;
  logic [2:0]       rd_req_ready;
  logic [2:0][4:0]  rd_req_addr;
  logic [2:0][1:0]  rd_req_lmul;
  logic [2:0][7:0]  rd_byte_en;
  logic [2:0]       rd_data_valid;
  logic [2:0]       rd_data_ready;
  logic [2:0][63:0] rd_data;
  logic [2:0]       rd_data_last;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][7:0]  wr_byte_en;
  logic [1:0][63:0] wr_data;
  logic [1:0]       wr_release;
  logic             rsv_en;
  logic [4:0]       rsv_addr;
  logic [1:0]       rsv_lmul;
  logic [31:0]      busy;

  int tests = 0;
  int fails = 0;

  vector_regfile_v4 dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_lmul(rd_req_lmul),
    .rd_byte_en(rd_byte_en), .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .rd_data_last(rd_data_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_byte_en(wr_byte_en), .wr_data(wr_data), .wr_release(wr_release),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_lmul(rsv_lmul), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wbe;
    logic [7:0]  rbe;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write1(input int p, input logic [4:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic rel);
    @(negedge clk);
    wr_en[p] = 1'b1; wr_addr[p] = a; wr_data[p] = d;
    wr_byte_en[p] = be; wr_release[p] = rel;
    @(negedge clk);
    wr_en[p] = 1'b0; wr_release[p] = 1'b0;
  endtask

  // Issue a request on port 0; returns at the negedge after the accept edge.
  task automatic rd_req(input logic [4:0] a, input logic [1:0] l, input logic [7:0] be);
    @(negedge clk);
    rd_req_valid[0] = 1'b1; rd_req_addr[0] = a; rd_req_lmul[0] = l; rd_byte_en[0] = be;
    @(negedge clk);
    rd_req_valid[0] = 1'b0;
  endtask

  task automatic wait_beat(output int lat);
    lat = 0;
    while (!rd_data_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  logic [63:0] got [8];
  logic        gl  [8];

  initial begin
    tbl[0] = '{"masked_v3",  5'd3,  64'h1122334455667788, 8'h0F, 8'hFF, 64'h0000000055667788};
    tbl[1] = '{"rdmask_v7",  5'd7,  64'hDEADBEEFCAFEF00D, 8'hFF, 8'hF0, 64'hDEADBEEF00000000};
    tbl[2] = '{"oddbyte_v31",5'd31, 64'h0123456789ABCDEF, 8'hAA, 8'hFF, 64'h010045008900CD00};
    tbl[3] = '{"zero_v0",    5'd0,  64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 64'h0};
    tbl[4] = '{"merge_v3",   5'd3,  64'hAAAAAAAAAAAAAAAA, 8'hF0, 8'hFF, 64'hAAAAAAAA55667788};

    reset = 1'b1;
    rd_req_valid = '0; rd_req_addr = '0; rd_req_lmul = '0; rd_byte_en = '0;
    rd_data_ready = 3'b111;
    wr_en = '0; wr_addr = '0; wr_byte_en = '0; wr_data = '0; wr_release = '0;
    rsv_en = 1'b0; rsv_addr = '0; rsv_lmul = '0;

    repeat (2) @(negedge clk);
    check("ready_in_reset", 64'(rd_req_ready), 64'h0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(rd_req_ready), 64'h7);
    check("busy_reset", 64'(busy), 64'h0);
    check("valid_reset", 64'(rd_data_valid), 64'h0);
    check("data_reset", rd_data[0], 64'h0);

    for (int i = 0; i < 5; i++) begin
      write1(0, tbl[i].wa, tbl[i].wd, tbl[i].wbe, 1'b0);
      rd_req(tbl[i].wa, 2'd0, tbl[i].rbe);
      wait_beat(lat);
      check({tbl[i].name, "_lat"}, 64'(lat), 64'd1);
      check({tbl[i].name, "_data"}, rd_data[0], tbl[i].exp);
      check({tbl[i].name, "_last"}, 64'(rd_data_last[0]), 64'd1);
    end

    // Group read with alternating backpressure
    for (int j = 0; j < 8; j++) write1(0, 5'(8 + j), 64'(8 + j), 8'hFF, 1'b0);
    rd_req(5'd9, 2'd3, 8'hFF);
    begin
      logic tog;
      logic pv;
      logic [63:0] pd;
      int k;
      tog = 1'b1; pv = 1'b0; pd = '0; k = 0;
      for (int c = 0; c < 40 && k < 8; c++) begin
        if (pv) begin
          check("grp_hold_valid", 64'(rd_data_valid[0]), 64'd1);
          check("grp_hold_data", rd_data[0], pd);
        end
        rd_data_ready[0] = tog;
        if (rd_data_valid[0] && tog) begin
          got[k] = rd_data[0]; gl[k] = rd_data_last[0]; k++;
        end
        pv = rd_data_valid[0] && !tog;
        pd = rd_data[0];
        tog = !tog;
        @(negedge clk);
      end
      check("grp_beats", 64'(k), 64'd8);
      for (int j = 0; j < 8; j++) begin
        check("grp_data", got[j], 64'(8 + j));
        check("grp_last", 64'(gl[j]), (j == 7) ? 64'd1 : 64'd0);
      end
    end
    rd_data_ready[0] = 1'b1;
    @(negedge clk);

    // Scoreboard stall and release bypass
    rsv_en = 1'b1; rsv_addr = 5'd4; rsv_lmul = 2'd0;
    @(negedge clk);
    rsv_en = 1'b0;
    check("sb_busy_set", 64'(busy[4]), 64'd1);
    rd_req(5'd4, 2'd0, 8'hFF);
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
        seen = seen | rd_data_valid[0];
        @(negedge clk);
      end
      check("sb_no_valid_busy", 64'(seen), 64'd0);
    end
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 64'hAB;
    wr_byte_en[0] = 8'hFF; wr_release[0] = 1'b1;
    @(negedge clk);
    wr_en[0] = 1'b0; wr_release[0] = 1'b0;
    check("sb_valid", 64'(rd_data_valid[0]), 64'd1);
    check("sb_data", rd_data[0], 64'hAB);
    check("sb_busy_clear", 64'(busy[4]), 64'd0);
    @(negedge clk);

    // Write port conflict
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
    wr_data[0] = 64'h0101010101010101; wr_data[1] = 64'h0202020202020202;
    wr_byte_en[0] = 8'hFF; wr_byte_en[1] = 8'hFF;
    @(negedge clk);
    wr_en = 2'b00;
    rd_req(5'd5, 2'd0, 8'hFF);
    wait_beat(lat);
    check("conflict_v5", rd_data[0], 64'h0202020202020202);

    // Reserve/release collision
    rsv_en = 1'b1; rsv_addr = 5'd6; rsv_lmul = 2'd0;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd6; wr_data[0] = 64'h6;
    wr_byte_en[0] = 8'hFF; wr_release[0] = 1'b1;
    @(negedge clk);
    rsv_en = 1'b0; wr_en[0] = 1'b0; wr_release[0] = 1'b0;
    check("collide_busy6", 64'(busy[6]), 64'd1);
    write1(0, 5'd6, 64'h6, 8'hFF, 1'b1);
    check("release_busy6", 64'(busy[6]), 64'd0);

    // Reset mid-stream
    rsv_en = 1'b1; rsv_addr = 5'd20; rsv_lmul = 2'd1;
    @(negedge clk);
    rsv_en = 1'b0;
    check("rsv_grp_busy", 64'(busy), 64'h0030_0000);
    rd_req(5'd8, 2'd3, 8'hFF);
    begin
      int c;
      c = 0;
      while (!(rd_data_valid[0] && rd_data[0] == 64'd11) && c < 20) begin
        @(negedge clk);
        c++;
      end
      check("rst_reach_beat3", 64'(c < 20), 64'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(rd_data_valid[0]), 64'd0);
    check("rst_data", rd_data[0], 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ready_low", 64'(rd_req_ready), 64'h0);
    reset = 1'b0;
    #1;
    check("rst_ready_high", 64'(rd_req_ready), 64'h7);
    rd_req(5'd8, 2'd0, 8'hFF);
    wait_beat(lat);
    check("rst_v8_lat", 64'(lat), 64'd1);
    check("rst_v8_zero", rd_data[0], 64'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_regfile_v4.md
# vector_regfile_v4

Parametrised vector register file for the vector accelerator datapath. It succeeds the fixed 64-bit/8-register/3-read file with:
- configurable VLEN, register count and read/write port counts;
- per-byte write enables;
- register-group (LMUL) read streaming through a per-port state machine with valid/ready handshakes;
- a busy scoreboard that holds reads of registers with outstanding writes.

It sits between the decode/issue stage, which reserves destinations and issues operand reads, and the lane ALUs and load unit, which consume reads and write results back.

## Interface
- VLEN, 64: register width in bits; multiple of 8.
- NUM_REGS, 32: register count; ≥ 8.
- NUM_RD, 3: read ports.
- NUM_WR, 2: write ports.
- ZERO_REG0, 1: when 1, v0 reads as zero, ignores writes and is never busy.
- ADDR_W, $clog2(NUM_REGS): register address width (derived).
- BYTES, VLEN/8: byte lanes per register (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- rd_req_valid  in  [NUM_RD]  read request valid.
- rd_req_ready  out  [NUM_RD]  port idle and able to accept.
- rd_req_addr  in  [NUM_RD][ADDR_W]  group base register.
- rd_req_lmul  in  [NUM_RD][2]  log2 group size (0..3 → 1..8 registers).
- rd_byte_en  in  [NUM_RD][BYTES]  byte lanes returned; disabled lanes read 0. Sampled at request and held for the whole stream.
- rd_data_valid  out  [NUM_RD]  output beat valid.
- rd_data_ready  in  [NUM_RD]  consumer accepts beat.
- rd_data  out  [NUM_RD][VLEN]  beat data.
- rd_data_last  out  [NUM_RD]  final beat of group.
- wr_en  in  [NUM_WR]  write strobe.
- wr_addr  in  [NUM_WR][ADDR_W]  destination register.
- wr_byte_en  in  [NUM_WR][BYTES]  byte write mask.
- wr_data  in  [NUM_WR][VLEN]  write data.
- wr_release  in  [NUM_WR]  with wr_en, clears busy[wr_addr].
- rsv_en  in  1  reserve destination group.
- rsv_addr  in  ADDR_W  reserve base register.
- rsv_lmul  in  2  reserve log2 group size.
- busy  out  [NUM_REGS]  scoreboard state.

## Operation
- **Base alignment:** base = addr with the low lmul bits forced to 0. Applies to reads and reservations; groups never wrap.
- **Writes:** each enabled byte of wr_data is stored into wr_addr. If two ports target the same register, the higher port index wins per byte.
- **Scoreboard:** rsv_en sets busy for base..base+2^lmul−1. wr_en & wr_release clears busy[wr_addr]. If a register is both reserved and released in the same cycle, it ends busy (reserve wins).
- **Read FSM, per port:**
  - **IDLE:** rd_req_ready=1. On rd_req_valid, latch base, lmul and byte_en, set beat=0, go to RUN.
  - **RUN:** rd_req_ready=0. Current register r = base+beat. A beat is loaded when the output slot is free (!rd_data_valid | rd_data_ready) and r is not busy. "Not busy" includes a register released by a write in the same cycle.
  - **Beat load:** rd_data = register contents, bypassed with same-cycle writes per byte, ANDed with the byte_en mask. rd_data_valid=1, rd_data_last=(beat==2^lmul−1), beat++.
  - **Stream end:** after the last beat is loaded, go to IDLE.
  - **Stall:** r busy, or slot full and not accepted → hold; no beat is lost or duplicated.
- **Output slot:** when accepted with no new load, rd_data_valid→0. rd_data and rd_data_last hold while valid & !ready.
- **ZERO_REG0=1:** r=0 returns all-zero data and never stalls.

## Timing
- **Reset:** all registers 0, busy 0, FSMs in IDLE, beat 0, rd_data_valid 0, rd_data 0, rd_data_last 0. rd_req_ready is 0 during any cycle with reset high, and 1 from the first cycle after.
- **Reset mid-stream:** the stream is aborted and pending output dropped. Reset-state outputs apply in the cycle after the reset edge.
- **Read latency:** request accepted at edge T → first beat valid after edge T+1 if not busy. With rd_data_ready held high, one beat per cycle; an LMUL=8 group completes in 8 consecutive cycles.
- **Back-to-back streams:** earliest next request is accepted the cycle after the last beat is loaded, giving one idle cycle on rd_data between streams.
- **Write visibility:** a write at edge T is visible to beats loaded at edge T (bypass) and all later beats.
- **busy timing:** reflects reservations and releases from edge T+1 onward.

## Test plan
- **Masked write:** write v3 = 0x1122334455667788, wr_byte_en=0x0F, prior value 0 → read v3 with lmul=0 and byte_en=0xFF returns 0x0000000055667788, valid one cycle after accept, last=1.
- **Group read with backpressure:** load v8..v15 with the values 8..15, request base v9 with lmul=3 → base aligns to v8. rd_data_ready toggles 1,0,1,… → eight beats 8..15 in order, each held while not ready, last=1 on 15.
- **Scoreboard stall:** reserve v4 (lmul=0), then request a v4 read → no valid while busy. Write 0xAB to v4 with wr_release → the beat is 0xAB in the same cycle as the release write, and busy[4] is 0 afterwards.
- **Write port conflict:** port0 and port1 both write v5 full-width with 0x01…01 and 0x02…02 → v5 = 0x02…02. Writes to v0 are ignored; a v0 read returns 0.
- **Reserve/release collision:** reserve and release v6 in the same cycle → busy[6] remains 1.
- **Reset mid-stream:** assert reset during beat 3 of an lmul=3 stream → next cycle valid=0, data=0, busy all 0. rd_req_ready=1 once reset is low, and v8 reads back 0.
